// File: rtl/dm_load_unit_pkg.sv
// rtl/dm_load_unit_pkg.sv - load unit state codes, read-type codes and size decode
package dm_load_unit_pkg;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_BEAT0 = 2'd1,
        LD_BEAT1 = 2'd2,
        LD_RESP  = 2'd3
    } ld_state_t;

    localparam logic [2:0] LD_BYTE_SIGNED   = 3'd0;
    localparam logic [2:0] LD_HALF_SIGNED   = 3'd1;
    localparam logic [2:0] LD_WORD_READ     = 3'd2;
    localparam logic [2:0] LD_BYTE_UNSIGNED = 3'd4;
    localparam logic [2:0] LD_HALF_UNSIGNED = 3'd5;

    // Unlisted codes fall back to a full word.
    function automatic logic [2:0] ld_size(input logic [2:0] req_type);
        case (req_type)
            LD_BYTE_SIGNED, LD_BYTE_UNSIGNED: return 3'd1;
            LD_HALF_SIGNED, LD_HALF_UNSIGNED: return 3'd2;
            default:                          return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// rtl/dm_load_unit_if.sv - request, memory-port and response bundle of the load unit
interface dm_load_unit_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [2:0]        req_type;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_type, resp_ready, mem_rd_data,
        input  req_ready, mem_rd_en, mem_rd_addr, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_type, resp_ready, mem_rd_data,
        output req_ready, mem_rd_en, mem_rd_addr, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/dm_lane_extract.sv
// rtl/dm_lane_extract.sv - picks the addressed byte/half/word from a two-beat window and extends it
module dm_lane_extract
    import dm_load_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0]         i_window,
    input  logic [$clog2(DATA_W/8)-1:0] i_off,
    input  logic [2:0]                  i_req_type,
    output logic [31:0]                 o_data
);
    logic [31:0] w_field;

    always_comb begin
        w_field = i_window[{i_off, 3'b000} +: 32];
        case (i_req_type)
            LD_BYTE_SIGNED:   o_data = {{24{w_field[7]}}, w_field[7:0]};
            LD_BYTE_UNSIGNED: o_data = {24'd0, w_field[7:0]};
            LD_HALF_SIGNED:   o_data = {{16{w_field[15]}}, w_field[15:0]};
            LD_HALF_UNSIGNED: o_data = {16'd0, w_field[15:0]};
            default:          o_data = w_field;
        endcase
    end
endmodule

// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - load path: one or two memory beats per request, then an extended result
module dm_load_unit
    import dm_load_unit_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    dm_load_unit_if.slave i_bus
);
    localparam int          B         = DATA_W / 8;
    localparam int          OFF_W     = $clog2(B);
    localparam logic [31:0] BUS_BYTES = 32'(B);

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_data;
    logic              r_rd2;
    logic [31:0]       r_rd_addr;
    logic              r_cross;
    logic [OFF_W-1:0]  r_off;
    logic [2:0]        r_type;
    logic [DATA_W-1:0] r_lo;

    logic                w_accept;
    logic                w_misaligned;
    logic                w_crossing;
    logic                w_err;
    logic [2:0]          w_size;
    logic [OFF_W-1:0]    w_off;
    logic [31:0]         w_base;
    logic [2*DATA_W-1:0] w_window;
    logic [31:0]         w_extract;

    always_comb begin
        w_size = ld_size(i_bus.req_type);
        w_off  = i_bus.req_addr[OFF_W-1:0];
        w_base = {i_bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};
        case (w_size)
            3'd2:    w_misaligned = i_bus.req_addr[0];
            3'd4:    w_misaligned = |i_bus.req_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
        w_crossing = (int'(w_off) + int'(w_size)) > B;
        w_err      = !ALLOW_MISALIGNED && w_misaligned;
        w_accept   = i_bus.req_valid && r_req_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= LD_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_IDLE:  if (w_accept) w_next = w_err ? LD_RESP : LD_BEAT0;
            LD_BEAT0: w_next = r_cross ? LD_BEAT1 : LD_RESP;
            LD_BEAT1: w_next = LD_RESP;
            LD_RESP:  if (i_bus.resp_ready) w_next = LD_IDLE;
            default:  w_next = LD_IDLE;
        endcase
    end

    // The first read leaves combinationally in the accept cycle; the second comes from r_rd2.
    always_comb begin
        i_bus.mem_rd_en   = ((r_state == LD_IDLE) && w_accept && !w_err) || r_rd2;
        i_bus.mem_rd_addr = ((r_state == LD_IDLE) && w_accept) ? w_base : r_rd_addr;
        w_window = (r_state == LD_BEAT1) ? {i_bus.mem_rd_data, r_lo}
                                         : {{DATA_W{1'b0}}, i_bus.mem_rd_data};
    end

    dm_lane_extract #(.DATA_W(DATA_W)) u_extract (
        .i_window   (w_window),
        .i_off      (r_off),
        .i_req_type (r_type),
        .o_data     (w_extract)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 32'd0;
            r_rd2        <= 1'b0;
            r_rd_addr    <= 32'd0;
            r_cross      <= 1'b0;
            r_off        <= '0;
            r_type       <= 3'd0;
            r_lo         <= '0;
        end else begin
            r_req_ready  <= (w_next == LD_IDLE);
            r_resp_valid <= (w_next == LD_RESP);
            r_rd2        <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (w_accept) begin
                        r_off   <= w_off;
                        r_type  <= i_bus.req_type;
                        r_cross <= w_crossing;
                        if (w_err) begin
                            r_resp_err  <= 1'b1;
                            r_resp_data <= 32'd0;
                        end else begin
                            r_resp_err <= 1'b0;
                            r_rd2      <= w_crossing;
                            r_rd_addr  <= w_base + BUS_BYTES;
                        end
                    end
                end
                LD_BEAT0: begin
                    r_lo <= i_bus.mem_rd_data;
                    if (!r_cross) r_resp_data <= w_extract;
                end
                LD_BEAT1: r_resp_data <= w_extract;
                default: ;
            endcase
        end
    end

    assign i_bus.req_ready  = r_req_ready;
    assign i_bus.resp_valid = r_resp_valid;
    assign i_bus.resp_data  = r_resp_data;
    assign i_bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - directed bench for three load unit flavours against a byte-level model
module tb_dm_load_unit;
    import dm_load_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_type = 3'd0;
    logic        resp_ready = 1'b0;
    int          sel = 0;

    dm_load_unit_if #(.DATA_W(32)) b0 ();
    dm_load_unit_if #(.DATA_W(64)) b1 ();
    dm_load_unit_if #(.DATA_W(32)) b2 ();

    dm_load_unit #(.DATA_W(32), .ALLOW_MISALIGNED(1'b1)) dut0 (.i_clk(clk), .i_reset(reset), .i_bus(b0.slave));
    dm_load_unit #(.DATA_W(64), .ALLOW_MISALIGNED(1'b1)) dut1 (.i_clk(clk), .i_reset(reset), .i_bus(b1.slave));
    dm_load_unit #(.DATA_W(32), .ALLOW_MISALIGNED(1'b0)) dut2 (.i_clk(clk), .i_reset(reset), .i_bus(b2.slave));

    assign b0.req_valid = req_valid && (sel == 0);
    assign b1.req_valid = req_valid && (sel == 1);
    assign b2.req_valid = req_valid && (sel == 2);
    assign b0.req_addr = req_addr;  assign b1.req_addr = req_addr;  assign b2.req_addr = req_addr;
    assign b0.req_type = req_type;  assign b1.req_type = req_type;  assign b2.req_type = req_type;
    assign b0.resp_ready = resp_ready; assign b1.resp_ready = resp_ready; assign b2.resp_ready = resp_ready;

    // Byte-addressed memory; addresses wrap at 256 bytes.
    logic [7:0] bmem [0:255];

    function automatic logic [63:0] rd_bus(input logic [31:0] a, input int nb);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = bmem[8'(a + 32'(i))];
        return v;
    endfunction

    always @(posedge clk) begin
        if (b0.mem_rd_en) b0.mem_rd_data <= rd_bus(b0.mem_rd_addr, 4)[31:0];
        if (b1.mem_rd_en) b1.mem_rd_data <= rd_bus(b1.mem_rd_addr, 8);
        if (b2.mem_rd_en) b2.mem_rd_data <= rd_bus(b2.mem_rd_addr, 4)[31:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m_ready, m_rd_en, m_resp_valid, m_resp_err;
    logic [31:0] m_rd_addr, m_resp_data;
    always_comb begin
        m_ready = b0.req_ready; m_rd_en = b0.mem_rd_en; m_rd_addr = b0.mem_rd_addr;
        m_resp_valid = b0.resp_valid; m_resp_data = b0.resp_data; m_resp_err = b0.resp_err;
        if (sel == 1) begin
            m_ready = b1.req_ready; m_rd_en = b1.mem_rd_en; m_rd_addr = b1.mem_rd_addr;
            m_resp_valid = b1.resp_valid; m_resp_data = b1.resp_data; m_resp_err = b1.resp_err;
        end else if (sel == 2) begin
            m_ready = b2.req_ready; m_rd_en = b2.mem_rd_en; m_rd_addr = b2.mem_rd_addr;
            m_resp_valid = b2.resp_valid; m_resp_data = b2.resp_data; m_resp_err = b2.resp_err;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected load result from first principles: gather bytes, extend, classify.
    function automatic void model(input int dw, input bit allow, input logic [31:0] addr, input logic [2:0] t,
                                  output logic [31:0] d, output bit e, output int lat, output int nrd);
        int  size, nb, off;
        bit  sgn;
        nb = dw / 8;
        case (t)
            LD_BYTE_SIGNED:   begin size = 1; sgn = 1'b1; end
            LD_BYTE_UNSIGNED: begin size = 1; sgn = 1'b0; end
            LD_HALF_SIGNED:   begin size = 2; sgn = 1'b1; end
            LD_HALF_UNSIGNED: begin size = 2; sgn = 1'b0; end
            default:          begin size = 4; sgn = 1'b0; end
        endcase
        off = int'(addr % 32'(nb));
        d = 32'd0;
        e = 1'b0;
        if (!allow && (addr % 32'(size)) != 0) begin
            e = 1'b1; lat = 1; nrd = 0;
            return;
        end
        for (int i = 0; i < size; i++) d[8*i +: 8] = bmem[8'(addr + 32'(i))];
        if (sgn && d[8*size-1]) for (int i = 8*size; i < 32; i++) d[i] = 1'b1;
        if (off + size > nb) begin lat = 3; nrd = 2; end
        else                 begin lat = 2; nrd = 1; end
    endfunction

    bit          busy = 1'b0, accepted = 1'b0, got_resp = 1'b0, done = 1'b0, use_lit = 1'b0;
    int          t_acc = 0, exp_lat = 0;
    logic [31:0] exp_data = 0, lit_data = 0, hold_data = 0;
    bit          exp_err = 1'b0, hold_err = 1'b0;
    logic [31:0] exp_rd_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (!busy) begin
                chk("idle_resp_valid", m_resp_valid, 0);
                chk("idle_rd_en", m_rd_en, 0);
            end else begin
                if (m_rd_en) begin
                    if (exp_rd_q.size() == 0) chk("extra_read", m_rd_en, 0);
                    else                      chk("rd_addr", m_rd_addr, exp_rd_q.pop_front());
                end
                if (req_valid && m_ready) begin
                    if (!accepted) begin accepted = 1'b1; t_acc = cyc; end
                    else chk("second_accept", m_ready, 0);
                end
                if (accepted && m_resp_valid) begin
                    if (!got_resp) begin
                        got_resp = 1'b1;
                        chk("latency", 32'(cyc - t_acc), 32'(exp_lat));
                        chk("resp_data", m_resp_data, exp_data);
                        chk("resp_err", m_resp_err, exp_err);
                        chk("reads_pending", 32'(exp_rd_q.size()), 0);
                        if (use_lit) chk("resp_literal", m_resp_data, lit_data);
                        hold_data = m_resp_data;
                        hold_err  = m_resp_err;
                    end else begin
                        chk("stall_data", m_resp_data, hold_data);
                        chk("stall_err", m_resp_err, hold_err);
                    end
                    chk("ready_in_resp", m_ready, 0);
                    if (resp_ready) done = 1'b1;
                end
            end
        end
    end

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) bmem[8'(a + 32'(i))] = v[8*i +: 8];
    endtask

    task automatic start_load(input int s, input logic [31:0] addr, input logic [2:0] t,
                              input bit ul, input logic [31:0] lit);
        int          dw, lat, nrd;
        logic [31:0] d, base;
        bit          e;
        dw = (s == 1) ? 64 : 32;
        model(dw, s != 2, addr, t, d, e, lat, nrd);
        base = addr & ~32'(dw / 8 - 1);
        exp_rd_q.delete();
        if (nrd >= 1) exp_rd_q.push_back(base);
        if (nrd == 2) exp_rd_q.push_back(base + 32'(dw / 8));
        exp_data = d; exp_err = e; exp_lat = lat; use_lit = ul; lit_data = lit;
        accepted = 1'b0; got_resp = 1'b0; done = 1'b0;
        sel = s; busy = 1'b1;
        req_addr = addr; req_type = t; req_valid = 1'b1;
        for (int n = 0; n < 20 && !accepted; n++) begin @(posedge clk); #1; end
        if (!accepted) chk("accept_timeout", m_ready, 1);
    endtask

    task automatic run_load(input int s, input logic [31:0] addr, input logic [2:0] t, input int stall,
                            input bit ul, input logic [31:0] lit);
        resp_ready = (stall == 0);
        start_load(s, addr, t, ul, lit);
        req_addr = ~addr;
        req_type = LD_BYTE_SIGNED;
        if (stall == 0) req_valid = 1'b0;
        for (int n = 0; n < 20 && !got_resp; n++) begin @(posedge clk); #1; end
        repeat (stall) begin @(posedge clk); #1; end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin @(posedge clk); #1; end
        if (!done) chk("resp_timeout", m_resp_valid, 1);
        busy = 1'b0;
        chk("ready_after_resp", m_ready, 1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", b0.req_ready, 0);
        chk("rst_ready1", b1.req_ready, 0);
        chk("rst_ready2", b2.req_ready, 0);
        chk("rst_valid", {b0.resp_valid, b1.resp_valid, b2.resp_valid}, 0);
        chk("rst_err", {b0.resp_err, b1.resp_err, b2.resp_err}, 0);
        chk("rst_rd_en", {b0.mem_rd_en, b1.mem_rd_en, b2.mem_rd_en}, 0);
        chk("rst_rd_addr", b0.mem_rd_addr | b1.mem_rd_addr | b2.mem_rd_addr, 0);
        chk("rst_data", b0.resp_data | b1.resp_data | b2.resp_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {b0.req_ready, b1.req_ready, b2.req_ready}, 3'b111);

        set_word(32'h10, 32'h8765_43A1);
        run_load(0, 32'h11, LD_BYTE_SIGNED,   0, 1, 32'h0000_0043);
        run_load(0, 32'h10, LD_BYTE_SIGNED,   0, 1, 32'hFFFF_FFA1);
        run_load(0, 32'h12, LD_HALF_UNSIGNED, 0, 1, 32'h0000_8765);
        run_load(1, 32'h12, LD_HALF_SIGNED,   0, 1, 32'hFFFF_8765);
        run_load(2, 32'h13, LD_BYTE_UNSIGNED, 0, 1, 32'h0000_0087);
        run_load(0, 32'h12, LD_HALF_UNSIGNED, 5, 1, 32'h0000_8765);

        set_word(32'h10, 32'h4433_2211);
        set_word(32'h14, 32'h8877_6655);
        run_load(0, 32'h13, LD_WORD_READ,   0, 1, 32'h7766_5544);
        run_load(0, 32'h13, LD_HALF_SIGNED, 0, 1, 32'h0000_5544);
        run_load(0, 32'h10, 3'd3,           0, 1, 32'h4433_2211);
        run_load(2, 32'h01, LD_HALF_SIGNED, 0, 1, 32'h0000_0000);
        run_load(2, 32'h12, LD_WORD_READ,   3, 1, 32'h0000_0000);
        run_load(1, 32'h17, LD_BYTE_SIGNED, 0, 1, 32'hFFFF_FF88);

        set_word(32'h00, 32'h4433_2211);
        set_word(32'h04, 32'h8877_6655);
        set_word(32'h08, 32'hCCBB_AA99);
        set_word(32'h0C, 32'h00FF_EEDD);
        set_word(32'hFC, 32'hDDCC_BBAA);
        run_load(1, 32'h06, LD_WORD_READ,     0, 1, 32'hAA99_8877);
        run_load(0, 32'hFFFF_FFFE, LD_WORD_READ, 0, 1, 32'h2211_DDCC);
        run_load(1, 32'h07, LD_HALF_UNSIGNED, 0, 1, 32'h0000_9988);

        // Reset while the first beat is in flight: the request must vanish.
        resp_ready = 1'b1;
        start_load(0, 32'h05, LD_BYTE_UNSIGNED, 0, 0);
        req_valid = 1'b0;
        reset = 1'b1;
        busy = 1'b0;
        exp_rd_q.delete();
        @(posedge clk); #1;
        chk("ready_in_reset", b0.req_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_post_reset", b0.req_ready, 1);
        repeat (4) begin @(posedge clk); #1; end
        resp_ready = 1'b0;
        run_load(0, 32'h04, LD_WORD_READ, 0, 1, 32'h8877_6655);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
